imem_fetch_ctrl: RTL

//  Instruction-fetch sequencer for the word-addressed instruction memory (1-cycle registered read).
//  - Owns the PC and drives the memory address.
//  - Tracks the single in-flight read and buffers returned words in a 2-entry queue.
//  - Presents {instr, pc} to decode over a valid/ready handshake.
//  - Handles branch/jump redirects and fetch enable. Sits between the memory and the decode stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/imem_fetch_ctrl_if.sv | 36 +++
 rtl/fetch_skid_fifo.sv | 60 ++++++
 rtl/imem_fetch_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
//   IMEM_DEPTH / AW : instruction memory size and PC width (PC wraps mod IMEM_DEPTH)
//   RESET_PC        : first word address fetched after reset
//   FQ_DEPTH        : depth of the fetch return queue
//   fetch_state_e   : controller FSM encoding
//   fq_entry_t      : one queue entry, {pc, instr}
package fetch_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int AW         = 8;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam int FQ_DEPTH   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction memory and decode.
//   imem_addr   : word address to memory (controller drives)
//   imem_data   : registered read data, valid the cycle after an issue
//   instr_valid : queue head valid (controller drives)
//   instr_data  : queue head instruction word
//   instr_pc    : word address of instr_data
//   instr_ready : decode accepts the head
// master = fetch controller side, slave = memory/decode side.
interface imem_fetch_ctrl_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry return queue holding {pc, instr} words from memory.
//   clk, rst : clock, synchronous active-high reset (clears entries to 0)
//   push/din : write an entry at the tail
//   pop      : remove the head (ignored when empty)
//   flush    : drop all entries; wins over push
//   count    : number of valid entries (0..2)
//   head     : oldest entry; holds its last value while empty
// Entry 0 is always the head, so an emptied queue keeps presenting the most
// recently consumed word rather than an older stale slot.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fq_entry_t  din,
  output logic [1:0] count,
  output fq_entry_t  head
);

  localparam logic [1:0] FULL = 2'(FQ_DEPTH);

  fq_entry_t  ent0;
  fq_entry_t  ent1;
  logic [1:0] cnt_q;
  logic       pop_eff;
  logic [1:0] cnt_after_pop;

  assign pop_eff       = pop & (cnt_q != 2'd0);
  assign cnt_after_pop = cnt_q - {1'b0, pop_eff};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      // Shift the second entry forward when the head leaves a full queue.
      if (pop_eff && cnt_q == FULL) ent0 <= ent1;
      if (push) begin
        if (cnt_after_pop == 2'd0) ent0 <= din;
        else                       ent1 <= din;
      end
      cnt_q <= cnt_after_pop + {1'b0, push};
    end
  end

  assign count = cnt_q;
  assign head  = ent0;

  // The controller's credit check must make this unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && cnt_after_pop == FULL))
    else $fatal(1, "fetch_skid_fifo: push while full");

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-cycle reads to the
// instruction memory, tracks the one in-flight read, queues returned words and
// hands {instr, pc} to decode over valid/ready. Handles redirects and enable.
//   clk, rst       : clock, synchronous active-high reset
//   fetch_en       : 1 = issue fetches; 0 = stop issuing (in-flight still lands)
//   redirect_valid : load PC from redirect_pc, flush queue and in-flight read
//   redirect_pc    : target word address (low AW bits used)
//   fetch_pc       : current PC (status)
//   bus            : memory address/data and decode handshake (master side)
//
// state | meaning
// IDLE  | not issuing; waits for fetch_en
// RUN   | issuing whenever fetch_en, no redirect and queue credit allow
module imem_fetch_ctrl
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       fetch_pc,
  imem_fetch_ctrl_if.master bus
);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] inflight_pc_q;
  logic          inflight_q;

  logic [1:0]    q_count;
  fq_entry_t     q_head;
  fq_entry_t     q_din;
  logic          pop;
  logic          issue;
  logic          credit;
  logic [1:0]    occ;
  logic          unused_redirect_hi;

  assign unused_redirect_hi = ^redirect_pc[31:AW];

  assign bus.instr_valid = (q_count != 2'd0);
  assign pop             = bus.instr_valid & bus.instr_ready;

  // Queued plus in-flight words may never exceed the queue depth; a pop in
  // the same cycle frees the slot the new read will land in.
  assign occ    = q_count + {1'b0, inflight_q};
  assign credit = (occ < 2'(FQ_DEPTH)) | ((occ == 2'(FQ_DEPTH)) & pop);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en) state_d = RUN;
      end
      RUN: begin
        if (!fetch_en) state_d = IDLE;
        issue = fetch_en & ~redirect_valid & credit;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (redirect_valid) pc_q <= redirect_pc[AW-1:0];
      else if (issue)     pc_q <= pc_q + AW'(1);
    end
  end

  assign q_din = '{pc: {{(32-AW){1'b0}}, inflight_pc_q}, instr: bus.imem_data};

  // A redirect flushes the queue and discards the word landing this cycle.
  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .count (q_count),
    .head  (q_head)
  );

  assign bus.imem_addr  = {{(32-AW){1'b0}}, pc_q};
  assign fetch_pc       = {{(32-AW){1'b0}}, pc_q};
  assign bus.instr_data = q_head.instr;
  assign bus.instr_pc   = q_head.pc;

endmodule
